// File: rtl/flag_unit.sv
// NVZ flag unit: masked EX flag commit, ID branch evaluation with optional EX forwarding, LIFO flag save stack.
// Commit and stack ops take effect at the next rising edge; br_taken and flag_hazard are combinational.
module flag_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int BYPASS      = 1,
  parameter int STACK_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         ex_opcode,
  input  logic                               ex_valid,
  input  logic                               ex_stall,
  input  logic                               ex_flush,
  input  logic [DATA_WIDTH-1:0]              alu_out,
  input  logic                               alu_ovfl,
  input  logic [2:0]                         id_cond,
  input  logic                               id_is_branch,
  input  logic                               flag_push,
  input  logic                               flag_pop,
  output logic [2:0]                         NVZ,
  output logic                               br_taken,
  output logic                               flag_hazard,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
  output logic                               stack_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [2:0]       nvz_q, nvz_d;
  logic [CNT_W-1:0] stack_cnt_q, stack_cnt_d;
  logic             stack_err_q, stack_err_d;
  logic [2:0]       stack_q [STACK_DEPTH];
  logic [2:0]       stack_d [STACK_DEPTH];

  logic [2:0] wmask;
  logic [2:0] ex_nvz;
  logic       ex_wen;
  logic [2:0] eff;
  logic [2:0] stack_top;
  logic       full, empty, push_ok, pop_ok;
  logic       cond_ok;

  always_comb begin
    case (ex_opcode)
      4'b0000, 4'b0001:                   wmask = 3'b111;
      4'b0011, 4'b0100, 4'b0101, 4'b0110: wmask = 3'b001;
      default:                            wmask = 3'b000;
    endcase
  end

  assign ex_nvz = {alu_out[DATA_WIDTH-1], alu_ovfl, ~|alu_out};
  assign ex_wen = ex_valid & ~ex_flush & ~ex_stall;

  assign full    = (stack_cnt_q == CNT_W'(STACK_DEPTH));
  assign empty   = (stack_cnt_q == '0);
  assign push_ok = flag_push & ~flag_pop & ~full;
  assign pop_ok  = flag_pop & ~flag_push & ~empty;

  always_comb begin
    stack_top = 3'b000;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CNT_W'(i + 1) == stack_cnt_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    nvz_d       = nvz_q;
    stack_cnt_d = stack_cnt_q;
    stack_err_d = stack_err_q | (flag_push & flag_pop) | (flag_push & full) | (flag_pop & empty);
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      // push saves the pre-edge flags, even if EX commits in the same cycle
      if (push_ok && CNT_W'(i) == stack_cnt_q) stack_d[i] = nvz_q;
    end
    if (push_ok) stack_cnt_d = stack_cnt_q + CNT_W'(1);
    if (pop_ok) begin
      stack_cnt_d = stack_cnt_q - CNT_W'(1);
      nvz_d       = stack_top;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (ex_wen && wmask[b]) nvz_d[b] = ex_nvz[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nvz_q       <= 3'b000;
      stack_cnt_q <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 3'b000;
    end else begin
      nvz_q       <= nvz_d;
      stack_cnt_q <= stack_cnt_d;
      stack_err_q <= stack_err_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  // a stalled EX value is already final, so forwarding does not wait for the stall to clear
  always_comb begin
    eff = nvz_q;
    if (BYPASS != 0) begin
      for (int b = 0; b < 3; b++) begin
        if (ex_valid && !ex_flush && wmask[b]) eff[b] = ex_nvz[b];
      end
    end
  end

  always_comb begin
    case (id_cond)
      3'b000:  cond_ok = ~eff[0];
      3'b001:  cond_ok = eff[0];
      3'b010:  cond_ok = ~eff[0] & ~eff[2];
      3'b011:  cond_ok = eff[2];
      3'b100:  cond_ok = eff[0] | ~eff[2];
      3'b101:  cond_ok = eff[2] | eff[0];
      3'b110:  cond_ok = eff[1];
      default: cond_ok = 1'b1;
    endcase
  end

  assign br_taken    = id_is_branch & cond_ok;
  assign flag_hazard = (BYPASS == 0) && id_is_branch && ex_valid && !ex_flush
                       && (wmask != 3'b000) && (id_cond != 3'b111);

  assign NVZ       = nvz_q;
  assign stack_cnt = stack_cnt_q;
  assign stack_err = stack_err_q;

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
Parametrised flag (NVZ) unit for the pipelined CPU. It commits ALU flags from the EX stage under stall and flush control. It evaluates branch conditions for the ID stage, with optional EX->ID flag forwarding or a hazard/stall request. It also provides a small flag save/restore stack for interrupt and exception entry and return.

Parameters:
DATA_WIDTH, 16, width of alu_out; N = alu_out[DATA_WIDTH-1]; Z = ~|alu_out over the full width.
BYPASS, 1, 1 = forward in-flight EX flags to branch evaluation; 0 = no forwarding, raise flag_hazard instead.
STACK_DEPTH, 2, number of entries in the flag save stack (>=1).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ex_opcode  in  4  opcode of the instruction in EX
ex_valid  in  1  EX holds a real instruction
ex_stall  in  1  EX is held this cycle; no flag commit
ex_flush  in  1  EX instruction is squashed; no flag commit
alu_out  in  DATA_WIDTH  ALU result of the EX instruction
alu_ovfl  in  1  ALU signed overflow of the EX instruction
id_cond  in  3  branch condition code of the ID instruction
id_is_branch  in  1  ID holds a conditional branch
flag_push  in  1  push the current committed NVZ onto the save stack
flag_pop  in  1  pop the stack top into NVZ
NVZ  out  3  committed flags {N,V,Z}
br_taken  out  1  condition result for the ID branch (combinational)
flag_hazard  out  1  ID branch must stall (always 0 when BYPASS=1)
stack_cnt  out  clog2(STACK_DEPTH+1)  number of occupied stack entries
stack_err  out  1  sticky error: push when full or pop when empty

Behaviour:
- Reset, synchronous when rst=1 at a clock edge: NVZ=000, stack_cnt=0, stack_err=0, all stack entries 000. rst overrides every other input.
- Write mask, NVZ order:
  - ADD (0000) and SUB (0001): 111.
  - XOR (0011), SLL (0100), SRA (0101), ROR (0110): 001.
  - All other opcodes: 000.
- Commit: ex_wen = ex_valid & ~ex_stall & ~ex_flush. Each flag bit with mask=1 and ex_wen=1 loads {alu_out[MSB], alu_ovfl, ~|alu_out} at the edge. Unmasked bits hold. Latency is 1 cycle: NVZ reflects the EX instruction on the cycle after commit.
- Effective flags for evaluation:
  - BYPASS=1: effective flags are the per-bit mux of the would-be-committed EX value, when ex_valid & ~ex_flush & mask bit, else NVZ. The mux ignores ex_stall, because the held value is final.
  - BYPASS=0: effective flags = NVZ.
- Condition codes:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | ~N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always 1
- br_taken = id_is_branch & cond(effective flags). br_taken is 0 when id_is_branch=0.
- flag_hazard (BYPASS=0 only) = id_is_branch & ex_valid & ~ex_flush & (write mask != 000) & (id_cond != 111). Asserted combinationally. It clears on the cycle after the EX instruction commits.
- Stack is LIFO:
  - Push writes the current NVZ (the pre-edge value, not the same-cycle EX update) at index stack_cnt, then stack_cnt+1.
  - Pop loads NVZ from entry stack_cnt-1, then stack_cnt-1.
  - Push when full, or pop when empty: the operation is ignored, state is unchanged, and stack_err is set (sticky until rst).
  - push & pop in the same cycle: both are ignored and stack_err is set.
- Priority on NVZ in one cycle: rst > valid pop > EX commit > hold. A pop overrides all three bits, even masked ones.
- Push in the same cycle as an EX commit: the stack gets the old NVZ, and NVZ gets the EX value.
- No wrap-around: stack_cnt saturates within 0..STACK_DEPTH.

Test Plan:
1. Reset, then ADD with alu_out=16'h8000, ovfl=1, ex_valid=1 -> next cycle NVZ=110. Follow with XOR giving alu_out=0 -> NVZ=111 (N and V held, Z set).
2. SUB with alu_out=0 and ex_stall=1 for 2 cycles, then released -> NVZ is unchanged during the stall and becomes 001 one cycle after release. Same instruction with ex_flush=1 -> NVZ never changes.
3. BYPASS=1: NVZ=000, EX SUB producing zero, ID id_cond=001 (EQ) with id_is_branch=1 -> br_taken=1 in the same cycle and flag_hazard=0.
4. BYPASS=0, same stimulus -> flag_hazard=1 and br_taken=0. Next cycle NVZ=001, flag_hazard=0, br_taken=1. id_cond=111 never raises the hazard.
5. STACK_DEPTH=2:
   - NVZ=101: push -> stack_cnt=1.
   - ADD sets NVZ=010: push -> stack_cnt=2.
   - Third push -> stack_err=1, stack_cnt=2.
   - Pop -> NVZ=010. Pop -> NVZ=101. Third pop -> stack_err stays 1, stack_cnt=0.
6. Pop in the same cycle as an ADD commit -> the popped value wins. rst asserted with push and commit pending -> all outputs are 0 next cycle.
